// File: rtl/uart_tx_frame.sv
// uart_tx_frame: byte FIFO feeding a UART framer on ref_clk; the PARITY bit exists only when UART_TX_PARITY_EN is defined.
// Latency: a byte pushed into an empty, idle block drives the start bit 2 cycles after the push.
// Backpressure: Tx_ready drops while the FIFO is full; a byte offered then is discarded.

// uart_tx_fifo: generic circular FIFO with a count register for full/empty.
// Latency: a written entry is visible at the head on the next cycle.
// Backpressure: in_rdy = !full, out_vld = !empty; an entry pops on out_vld && out_rdy.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   ref_clk,
    input  logic                   reset,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [WIDTH-1:0]       in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [WIDTH-1:0]       out_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_rdy  = (count != (AW+1)'(DEPTH));
    assign out_vld = (count != '0);
    assign push    = in_vld && in_rdy;
    assign pop     = out_rdy && out_vld;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge ref_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

// uart_tx_frame: start, 8 data bits LSB first, optional even parity, STOP_BITS stop bits.
// Latency: pop on the cycle after the push, line falls on the next edge; frames run back-to-back.
// Backpressure: Tx_ready = FIFO not full; the framer drains the FIFO without stalling.
module uart_tx_frame #(
    parameter int CLKS_PER_BAUD = 15259,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_BITS     = 2
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic [7:0] par_in,
    input  logic       Tx_valid,
    output logic       Tx_ready,
    output logic       ser_out,
    output logic       Tx_busy
);
    localparam int              CW        = $clog2(CLKS_PER_BAUD);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BAUD - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             baud_cnt;
    logic [2:0]                bit_cnt;
    logic [7:0]                shreg;
`ifdef UART_TX_PARITY_EN
    logic                      par_bit;
`endif
    logic                      baud_tick;
    logic                      stop_done;
    logic                      pop;
    logic                      ser_bit;
    logic                      fifo_vld;
    logic [7:0]                fifo_dat;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .ref_clk (ref_clk),
        .reset   (reset),
        .in_vld  (Tx_valid),
        .in_rdy  (Tx_ready),
        .in_dat  (par_in),
        .out_vld (fifo_vld),
        .out_rdy (pop),
        .out_dat (fifo_dat),
        .count   (fifo_cnt)
    );

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign stop_done = baud_tick && (bit_cnt == STOP_LAST);
    assign Tx_busy   = (state != IDLE) || (fifo_cnt != '0);

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (fifo_vld) state_nxt = START;
            START:  if (baud_tick) state_nxt = DATA;
            DATA: begin
                if (baud_tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_tick) state_nxt = STOP;
`endif
            STOP:   if (stop_done) state_nxt = fifo_vld ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        ser_bit = 1'b1;
        case (state)
            IDLE:   pop     = fifo_vld;
            START:  ser_bit = 1'b0;
            DATA:   ser_bit = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: ser_bit = par_bit;
`endif
            STOP:   pop     = fifo_vld && stop_done;
            default: ;
        endcase
    end

    // Line is registered from the current state, so every bit lags the FSM by one cycle.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            ser_out  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            ser_out <= ser_bit;
            if (state == IDLE || baud_tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
            if (pop) begin
                shreg   <= fifo_dat;
`ifdef UART_TX_PARITY_EN
                par_bit <= ^fifo_dat;
`endif
            end else if (state == DATA && baud_tick) begin
                shreg <= {1'b0, shreg[7:1]};
            end
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (baud_tick) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end
endmodule
